// File: rtl/tcp_tx_scheduler_pkg.sv
// Shared TCP transmit types: packet descriptor, requester IDs and scheduler FSM states.
package tcp_tx_scheduler_pkg;

    typedef struct packed {
        logic [31:0] seq_num;
        logic [15:0] payload_len;
        logic [7:0]  flags;
    } tcp_packet_info_s;

    localparam logic [1:0] REQ_RETX = 2'd0;
    localparam logic [1:0] REQ_CTRL = 2'd1;
    localparam logic [1:0] REQ_DATA = 2'd2;
    localparam logic [1:0] NO_GRANT = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } tx_state_e;

    function automatic logic [1:0] onehot_to_id(input logic [2:0] oh);
        case (oh)
            3'b001:  return REQ_RETX;
            3'b010:  return REQ_CTRL;
            3'b100:  return REQ_DATA;
            default: return NO_GRANT;
        endcase
    endfunction

endpackage

// File: rtl/tcp_tx_scheduler_if.sv
// Requester handshake and tcp_sender launch signals of the transmit scheduler.
interface tcp_tx_scheduler_if;
    import tcp_tx_scheduler_pkg::*;

    logic [2:0]             req_valid;
    tcp_packet_info_s [2:0] req_info;
    logic [2:0]             req_ready;
    logic                   sender_start;
    tcp_packet_info_s       sender_info;
    logic                   sender_busy;
    logic [1:0]             cur_grant;
    logic                   err_timeout;
    logic [15:0]            pkts_sent;

    modport master (
        output req_valid, req_info, sender_busy,
        input  req_ready, sender_start, sender_info, cur_grant, err_timeout, pkts_sent
    );

    modport slave (
        input  req_valid, req_info, sender_busy,
        output req_ready, sender_start, sender_info, cur_grant, err_timeout, pkts_sent
    );

endinterface

// File: rtl/tcp_tx_scheduler_rr_arbiter.sv
// Three-way round-robin arbiter with optional strict priority for requester 0.
module tcp_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic       prio_en,
    input  logic       accept,
    output logic [2:0] grant
);
    logic [1:0] ptr;

    function automatic logic [2:0] pick(input logic [2:0] r, input logic [1:0] first);
        case (first)
            2'd0:    return r[0] ? 3'b001 : r[1] ? 3'b010 : r[2] ? 3'b100 : 3'b000;
            2'd1:    return r[1] ? 3'b010 : r[2] ? 3'b100 : r[0] ? 3'b001 : 3'b000;
            default: return r[2] ? 3'b100 : r[0] ? 3'b001 : r[1] ? 3'b010 : 3'b000;
        endcase
    endfunction

    always_comb begin
        grant = pick(req, ptr);
        if (prio_en && req[0]) grant = 3'b001;
    end

    // Pointer moves to the requester after the winner, only when the grant is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 2'd0;
        end else if (accept) begin
            case (grant)
                3'b001:  ptr <= 2'd1;
                3'b010:  ptr <= 2'd2;
                default: ptr <= 2'd0;
            endcase
        end
    end

endmodule

// File: rtl/tcp_tx_scheduler.sv
// Arbitrates three packet sources onto a single tcp_sender and tracks each launch to completion.
module tcp_tx_scheduler
    import tcp_tx_scheduler_pkg::*;
#(
    parameter int START_TIMEOUT = 16,
    parameter bit PRIO_RETX     = 1'b1
) (
    input logic               clk,
    input logic               rst,
    tcp_tx_scheduler_if.slave bus
);
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LIMIT = TW'(START_TIMEOUT);

    tx_state_e        state;
    logic [TW-1:0]    tmo_cnt;
    logic [TW-1:0]    tmo_next;
    logic [2:0]       grant;
    logic [1:0]       grant_id;
    logic             accept;
    logic             start_q;
    logic             err_q;
    logic [1:0]       grant_q;
    logic [15:0]      pkts_cnt;
    tcp_packet_info_s info_q;

    tcp_rr_arbiter u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (bus.req_valid),
        .prio_en (PRIO_RETX),
        .accept  (accept),
        .grant   (grant)
    );

    // Grants are only offered while idle and the sender is free.
    assign bus.req_ready = (state == IDLE && !bus.sender_busy && !rst) ? grant : 3'b000;
    assign accept        = |bus.req_ready;
    assign grant_id      = onehot_to_id(grant);
    assign tmo_next      = (tmo_cnt == TMO_LIMIT) ? tmo_cnt : tmo_cnt + 1'b1;

    assign bus.sender_start = start_q;
    assign bus.sender_info  = info_q;
    assign bus.cur_grant    = grant_q;
    assign bus.err_timeout  = err_q;
    assign bus.pkts_sent    = pkts_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            grant_q  <= NO_GRANT;
            pkts_cnt <= 16'd0;
            info_q   <= '0;
            tmo_cnt  <= '0;
        end else begin
            start_q <= 1'b0;
            err_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        info_q  <= bus.req_info[grant_id];
                        grant_q <= grant_id;
                        start_q <= 1'b1;
                        state   <= LAUNCH;
                    end
                end
                LAUNCH: begin
                    tmo_cnt <= '0;
                    state   <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (bus.sender_busy) begin
                        state <= WAIT_DONE;
                    end else begin
                        tmo_cnt <= tmo_next;
                        if (tmo_next == TMO_LIMIT) begin
                            err_q   <= 1'b1;
                            grant_q <= NO_GRANT;
                            state   <= IDLE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!bus.sender_busy) begin
                        pkts_cnt <= pkts_cnt + 16'd1;
                        grant_q  <= NO_GRANT;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_tx_scheduler.sv
// Directed bench for tcp_tx_scheduler: vector table plus corner-case sequences.
module tb_tcp_tx_scheduler;
    import tcp_tx_scheduler_pkg::*;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    tcp_tx_scheduler_if bus();
    tcp_tx_scheduler_if bus_rr();

    tcp_tx_scheduler #(.START_TIMEOUT(16), .PRIO_RETX(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    tcp_tx_scheduler #(.START_TIMEOUT(16), .PRIO_RETX(1'b0)) dut_rr (
        .clk (clk),
        .rst (rst),
        .bus (bus_rr.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  v;
        logic        b;
        logic [2:0]  rdy;
        logic        st;
        logic [1:0]  g;
        logic [15:0] p;
    } vec_t;

    vec_t             vecs[$];
    tcp_packet_info_s infos [3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic [2:0] v, input logic b, input logic [2:0] rdy,
                       input logic st, input logic [1:0] g, input logic [15:0] p);
        vec_t t;
        t.v = v; t.b = b; t.rdy = rdy; t.st = st; t.g = g; t.p = p;
        vecs.push_back(t);
    endtask

    // One full transfer: accept, launch, one busy cycle, completion.
    task automatic add_xfer(input logic [2:0] v, input logic [2:0] rdy,
                            input logic [1:0] g, input logic [15:0] p);
        add(v, 1'b0, rdy,    1'b0, NO_GRANT, p);
        add(v, 1'b0, 3'b000, 1'b1, g,        p);
        add(v, 1'b1, 3'b000, 1'b0, g,        p);
        add(v, 1'b0, 3'b000, 1'b0, g,        p);
    endtask

    task automatic drive(input logic r, input logic [2:0] v, input logic b);
        @(negedge clk);
        rst             = r;
        bus.req_valid   = v;
        bus.sender_busy = b;
        #1;
    endtask

    task automatic drive_rr(input logic [2:0] v, input logic b);
        @(negedge clk);
        bus_rr.req_valid   = v;
        bus_rr.sender_busy = b;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            infos[i].seq_num     = 32'hA000_0000 + 32'(i);
            infos[i].payload_len = 16'd64 * 16'(i + 1);
            infos[i].flags       = 8'h10 + 8'(i);
        end
        bus.req_info       = {infos[2], infos[1], infos[0]};
        bus_rr.req_info    = {infos[2], infos[1], infos[0]};
        bus.req_valid      = 3'b000;
        bus.sender_busy    = 1'b0;
        bus_rr.req_valid   = 3'b000;
        bus_rr.sender_busy = 1'b0;
        rst                = 1'b1;

        add(3'b000, 1'b0, 3'b000, 1'b0, NO_GRANT, 16'd0);
        add(3'b100, 1'b0, 3'b100, 1'b0, NO_GRANT, 16'd0);
        add(3'b000, 1'b0, 3'b000, 1'b1, 2'd2,     16'd0);
        for (int i = 0; i < 5; i++) add(3'b000, 1'b1, 3'b000, 1'b0, 2'd2, 16'd0);
        add(3'b000, 1'b0, 3'b000, 1'b0, 2'd2,     16'd0);
        add(3'b000, 1'b0, 3'b000, 1'b0, NO_GRANT, 16'd1);
        add(3'b010, 1'b1, 3'b000, 1'b0, NO_GRANT, 16'd1);
        add(3'b000, 1'b0, 3'b000, 1'b0, NO_GRANT, 16'd1);
        add_xfer(3'b111, 3'b001, 2'd0, 16'd1);
        add_xfer(3'b111, 3'b001, 2'd0, 16'd2);
        add_xfer(3'b110, 3'b010, 2'd1, 16'd3);
        add_xfer(3'b110, 3'b100, 2'd2, 16'd4);
        add_xfer(3'b110, 3'b010, 2'd1, 16'd5);
        add(3'b000, 1'b0, 3'b000, 1'b0, NO_GRANT, 16'd6);

        drive(1'b1, 3'b000, 1'b0);
        drive(1'b1, 3'b000, 1'b0);

        foreach (vecs[i]) begin
            drive(1'b0, vecs[i].v, vecs[i].b);
            check($sformatf("vec%0d_ready", i), 64'(bus.req_ready),    64'(vecs[i].rdy));
            check($sformatf("vec%0d_start", i), 64'(bus.sender_start), 64'(vecs[i].st));
            check($sformatf("vec%0d_grant", i), 64'(bus.cur_grant),    64'(vecs[i].g));
            check($sformatf("vec%0d_err", i),   64'(bus.err_timeout),  64'(0));
            check($sformatf("vec%0d_pkts", i),  64'(bus.pkts_sent),    64'(vecs[i].p));
            if (vecs[i].g != NO_GRANT)
                check($sformatf("vec%0d_info", i), 64'(bus.sender_info), 64'(infos[vecs[i].g]));
        end

        // Sender never goes busy: timeout 16 cycles after entering WAIT_BUSY.
        drive(1'b0, 3'b100, 1'b0);
        check("tmo_ready", 64'(bus.req_ready), 64'(3'b100));
        drive(1'b0, 3'b000, 1'b0);
        check("tmo_start", 64'(bus.sender_start), 64'(1));
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 3'b000, 1'b0);
            check($sformatf("tmo_early_err%0d", k), 64'(bus.err_timeout), 64'(0));
        end
        drive(1'b0, 3'b000, 1'b0);
        check("tmo_err",   64'(bus.err_timeout), 64'(1));
        check("tmo_grant", 64'(bus.cur_grant),   64'(NO_GRANT));
        check("tmo_pkts",  64'(bus.pkts_sent),   64'(6));
        drive(1'b0, 3'b010, 1'b0);
        check("tmo_err_pulse", 64'(bus.err_timeout), 64'(0));
        check("tmo_next_ready", 64'(bus.req_ready), 64'(3'b010));
        drive(1'b0, 3'b000, 1'b0);
        check("tmo_next_start", 64'(bus.sender_start), 64'(1));
        check("tmo_next_grant", 64'(bus.cur_grant), 64'(REQ_CTRL));
        drive(1'b0, 3'b000, 1'b1);
        drive(1'b0, 3'b000, 1'b0);
        drive(1'b0, 3'b000, 1'b0);
        check("tmo_next_pkts", 64'(bus.pkts_sent), 64'(7));

        // Reset while in WAIT_DONE.
        drive(1'b0, 3'b001, 1'b0);
        check("rst_ready", 64'(bus.req_ready), 64'(3'b001));
        drive(1'b0, 3'b000, 1'b0);
        drive(1'b0, 3'b000, 1'b1);
        drive(1'b0, 3'b000, 1'b1);
        check("rst_pre_grant", 64'(bus.cur_grant), 64'(REQ_RETX));
        drive(1'b1, 3'b000, 1'b1);
        drive(1'b0, 3'b000, 1'b0);
        check("rst_ready0", 64'(bus.req_ready),    64'(0));
        check("rst_start0", 64'(bus.sender_start), 64'(0));
        check("rst_grant",  64'(bus.cur_grant),    64'(NO_GRANT));
        check("rst_err",    64'(bus.err_timeout),  64'(0));
        check("rst_pkts",   64'(bus.pkts_sent),    64'(0));
        check("rst_info",   64'(bus.sender_info),  64'(0));
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 3'b000, 1'b0);
            check($sformatf("rst_no_start%0d", k), 64'(bus.sender_start), 64'(0));
        end
        drive(1'b0, 3'b100, 1'b0);
        check("rst_rereq_ready", 64'(bus.req_ready), 64'(3'b100));
        drive(1'b0, 3'b000, 1'b0);
        check("rst_rereq_start", 64'(bus.sender_start), 64'(1));
        drive(1'b0, 3'b000, 1'b1);
        drive(1'b0, 3'b000, 1'b0);
        drive(1'b0, 3'b000, 1'b0);
        check("rst_rereq_pkts", 64'(bus.pkts_sent), 64'(1));

        // Completion counter wraps from FFFF to 0.
        force dut.pkts_cnt = 16'hFFFF;
        #1;
        release dut.pkts_cnt;
        drive(1'b0, 3'b000, 1'b0);
        check("wrap_pre", 64'(bus.pkts_sent), 64'(16'hFFFF));
        drive(1'b0, 3'b010, 1'b0);
        check("wrap_ready", 64'(bus.req_ready), 64'(3'b010));
        drive(1'b0, 3'b000, 1'b0);
        drive(1'b0, 3'b000, 1'b1);
        drive(1'b0, 3'b000, 1'b0);
        drive(1'b0, 3'b000, 1'b0);
        check("wrap_pkts", 64'(bus.pkts_sent), 64'(0));

        // Pure round-robin instance with all requesters valid.
        for (int k = 0; k < 6; k++) begin
            drive_rr(3'b111, 1'b0);
            check($sformatf("rr%0d_ready", k), 64'(bus_rr.req_ready), 64'(3'b001 << (k % 3)));
            drive_rr(3'b111, 1'b0);
            check($sformatf("rr%0d_start", k), 64'(bus_rr.sender_start), 64'(1));
            check($sformatf("rr%0d_grant", k), 64'(bus_rr.cur_grant), 64'(k % 3));
            check($sformatf("rr%0d_info", k), 64'(bus_rr.sender_info), 64'(infos[k % 3]));
            drive_rr(3'b111, 1'b1);
            check($sformatf("rr%0d_start_wb", k), 64'(bus_rr.sender_start), 64'(0));
            drive_rr(3'b111, 1'b0);
            check($sformatf("rr%0d_start_wd", k), 64'(bus_rr.sender_start), 64'(0));
            check($sformatf("rr%0d_err", k), 64'(bus_rr.err_timeout), 64'(0));
        end
        drive_rr(3'b000, 1'b0);
        check("rr_pkts", 64'(bus_rr.pkts_sent), 64'(6));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tcp_tx_scheduler.md
TCP_TX_SCHEDULER -- requirements
Module: tcp_tx_scheduler

Interface
REQ-001 Parameter START_TIMEOUT, default 16: max cycles to wait for sender_busy rise after a launch.
REQ-002 Parameter PRIO_RETX, default 1: 1 = requester 0 (retransmit) has strict priority; 0 = pure round-robin.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  3  per-requester launch request; bit 0 retransmit, bit 1 control/ACK, bit 2 data.
REQ-006 req_info  input  3 x tcp_packet_info_s  per-requester packet descriptor; held stable while req_valid is high.
REQ-007 req_ready  output  3  one-hot accept; the request is consumed when req_valid & req_ready are both high.
REQ-008 sender_start  output  1  one-cycle launch pulse to tcp_sender.
REQ-009 sender_info  output  tcp_packet_info_s  descriptor to tcp_sender; valid from launch until return to IDLE.
REQ-010 sender_busy  input  1  tcp_sender busy flag.
REQ-011 cur_grant  output  2  ID of the requester being served; 2'd3 when idle.
REQ-012 err_timeout  output  1  one-cycle pulse when sender_busy fails to rise within START_TIMEOUT cycles.
REQ-013 pkts_sent  output  16  count of completed launches; wraps modulo 2^16.

Function
REQ-014 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE.
REQ-015 IDLE, no grant: any req_valid high and sender_busy low -> one-hot req_ready asserted combinationally, winner's req_info registered, rr pointer updated, next state LAUNCH.
REQ-016 IDLE with sender_busy high: no req_ready asserted; remain in IDLE.
REQ-017 Arbitration with PRIO_RETX=1: bit 0 wins whenever valid; otherwise round-robin between bits 1 and 2.
REQ-018 Arbitration with PRIO_RETX=0: round-robin over all three requesters, starting at the index after the last grant.
REQ-019 Round-robin pointer reset value selects bit 0 first; the pointer changes only on an accepted grant.
REQ-020 LAUNCH: sender_start=1 for exactly one cycle; sender_info = latched descriptor; next state WAIT_BUSY; timeout counter cleared.
REQ-021 WAIT_BUSY: sender_busy high -> WAIT_DONE.
REQ-022 WAIT_BUSY timeout: counter reaches START_TIMEOUT with busy still low -> err_timeout pulse, IDLE, pkts_sent not incremented.
REQ-023 WAIT_DONE: sender_busy low -> pkts_sent += 1, IDLE; no new grant may occur in this same cycle.
REQ-024 Latency: req_valid in an idle cycle N -> req_ready at N, sender_start at N+1.
REQ-025 Back-to-back: minimum gap between two sender_start pulses is 4 cycles (busy of 1 cycle).
REQ-026 sender_info and cur_grant hold stable from LAUNCH through WAIT_DONE; the requester may deassert req_valid after acceptance without effect.
REQ-027 req_valid falling before acceptance is legal; the request is dropped without side effects.
REQ-028 Timeout counter is sized $clog2(START_TIMEOUT+1) bits and saturates.

Reset
REQ-029 rst high at any clock edge, including mid-transfer: state=IDLE, sender_start=0, req_ready=0, err_timeout=0, cur_grant=3, pkts_sent=0, sender_info=0, rr pointer=0, timeout counter=0.
REQ-030 No launch is re-issued after reset; requesters must re-request.

Structure
REQ-031 tcp_packet_info_s, requester ID constants (REQ_RETX=0, REQ_CTRL=1, REQ_DATA=2) and the FSM state enum belong in the shared tcp package.
REQ-032 Arbitration logic is one sub-module, tcp_rr_arbiter (3-way, priority-override input, one-hot grant, pointer update on accept).

Verification
REQ-033 Only bit 2 valid, busy high for 5 cycles after start -> req_ready=3'b100 at cycle 0, start at 1, pkts_sent=1 after busy falls.
REQ-034 PRIO_RETX=1, all three valid continuously -> grant order 0,0,0... while bit 0 is held; drop bit 0 -> alternating 1,2,1,2.
REQ-035 PRIO_RETX=0, all valid -> grant order 0,1,2,0,1,2; exactly one start per grant.
REQ-036 sender_busy never rises -> err_timeout at 16 cycles after WAIT_BUSY entry, IDLE, pkts_sent unchanged, next request served.
REQ-037 rst asserted in WAIT_DONE -> all outputs at reset values next cycle; no start until a new req_valid.
REQ-038 pkts_sent at 16'hFFFF plus one completion -> 16'h0000.
